lane_render: RTL

LANE_RENDER -- requirements
Module: lane_render

---
 rtl/display_pkg.sv | 23 ++
 rtl/lane_flash.sv | 39 +++
 rtl/lane_render.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared display constants and the pixel region classification for the lane renderer.
package display_pkg;

  localparam logic [11:0] WHITE     = 12'hFFF;
  localparam logic [11:0] BLACK     = 12'h000;
  localparam logic [11:0] BLUE      = 12'hF00;
  localparam logic [11:0] RED       = 12'h00F;
  localparam logic [11:0] GREY      = 12'h777;
  localparam logic [11:0] DEEP_GREY = 12'h444;
  localparam logic [11:0] FLASH     = 12'hCCC;

  typedef enum logic [1:0] {
    RC_OUTSIDE = 2'd0,
    RC_WHITE   = 2'd1,
    RC_KEY     = 2'd2,
    RC_NOTE    = 2'd3
  } region_e;

  function automatic logic in_span(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/lane_flash.sv
// Per-lane hit-flash frame counter: reloads on a judged hit, counts frames down to zero.
module lane_flash #(
  parameter int FLASH_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start_i,
  input  logic hit_i,
  output logic active_o
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);

  logic [FW-1:0] cnt_d, cnt_q;

  // Next count: a hit in the same cycle as frame_start still reloads.
  always_comb begin
    cnt_d = cnt_q;
    if (hit_i) begin
      cnt_d = FW'(FLASH_FRAMES);
    end else if (frame_start_i && (cnt_q != {FW{1'b0}})) begin
      cnt_d = cnt_q - {{(FW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {FW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_o = (cnt_q != {FW{1'b0}});

endmodule

// File: rtl/lane_render.sv
// Two-stage rhythm-game playfield renderer (borders, judge line, keys, notes, hit flash).
// Optional background pass-through outside the playfield with LANE_RENDER_BG_EN.
module lane_render
  import display_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int LANE_W       = 100,
  parameter int BORDER_W     = 6,
  parameter int X0           = 50,
  parameter int JUDGE_Y      = 440,
  parameter int TRACK_H      = 480,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_valid,
  input  logic [9:0]                 x,
  input  logic [8:0]                 y,
  input  logic                       frame_start,
  input  logic [LANES-1:0]           key,
  input  logic [LANES-1:0]           judge_hit,
  input  logic [LANES*TRACK_H-1:0]   tracks,
`ifdef LANE_RENDER_BG_EN
  input  logic [11:0]                bg_color,
  input  logic                       bg_active,
`endif
  output logic [11:0]                color,
  output logic                       color_valid
);

  localparam int P  = LANE_W + BORDER_W;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TW = $clog2(LANES * TRACK_H);

  logic [LANES-1:0] flash_nz;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_flash #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
      .clk           (clk),
      .rst           (rst),
      .frame_start_i (frame_start),
      .hit_i         (judge_hit[g]),
      .active_o      (flash_nz[g])
    );
  end

  region_e        region_d, region_q;
  logic [LW-1:0]  lane_d, lane_q;
  logic           note_d, note_q;
  logic           key_d, key_q;
  logic           interior_s;
  logic [TW-1:0]  bit_idx_s;
  logic           valid1_q, valid2_q;
  logic [11:0]    color_d, color_q;
`ifdef LANE_RENDER_BG_EN
  logic [11:0]    bg_color_q;
  logic           bg_active_q;
`endif

  // Stage 1 classification: which lane interior (if any) and which region the pixel hits.
  always_comb begin
    region_d   = RC_OUTSIDE;
    lane_d     = {LW{1'b0}};
    note_d     = 1'b0;
    key_d      = 1'b0;
    interior_s = 1'b0;
    bit_idx_s  = {TW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (in_span(int'(x), X0 + i*P + BORDER_W, X0 + (i+1)*P - 1)) begin
        interior_s = 1'b1;
        lane_d     = LW'(i);
        key_d      = key[i];
        bit_idx_s  = TW'(i*TRACK_H + int'(y));
        if (int'(y) < TRACK_H) begin
          note_d = tracks[bit_idx_s];
        end else begin
          note_d = 1'b0;
        end
      end else begin
        interior_s = interior_s;
      end
    end
    if (!in_span(int'(x), X0, X0 + LANES*P + BORDER_W - 1)) begin
      region_d = RC_OUTSIDE;
    end else if (!interior_s || in_span(int'(y), JUDGE_Y, JUDGE_Y + BORDER_W - 1)) begin
      region_d = RC_WHITE;
    end else if (int'(y) > JUDGE_Y + BORDER_W - 1) begin
      region_d = RC_KEY;
    end else begin
      region_d = RC_NOTE;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid1_q    <= 1'b0;
      region_q    <= RC_OUTSIDE;
      lane_q      <= {LW{1'b0}};
      note_q      <= 1'b0;
      key_q       <= 1'b0;
`ifdef LANE_RENDER_BG_EN
      bg_color_q  <= 12'h000;
      bg_active_q <= 1'b0;
`endif
    end else begin
      valid1_q    <= pix_valid;
      region_q    <= region_d;
      lane_q      <= lane_d;
      note_q      <= note_d;
      key_q       <= key_d;
`ifdef LANE_RENDER_BG_EN
      bg_color_q  <= bg_color;
      bg_active_q <= bg_active;
`endif
    end
  end

  // Stage 2 color selection in priority order; invalid pixels render black.
  always_comb begin
    color_d = BLACK;
    if (!valid1_q) begin
      color_d = BLACK;
    end else begin
      case (region_q)
        RC_WHITE: color_d = WHITE;
        RC_KEY:   color_d = key_q ? GREY : DEEP_GREY;
        RC_NOTE: begin
          if (note_q) begin
            color_d = BLUE;
          end else if (flash_nz[lane_q]) begin
            color_d = FLASH;
          end else if (key_q) begin
            color_d = GREY;
          end else begin
            color_d = BLACK;
          end
        end
        RC_OUTSIDE: begin
`ifdef LANE_RENDER_BG_EN
          color_d = bg_active_q ? bg_color_q : BLACK;
`else
          color_d = BLACK;
`endif
        end
        default: color_d = BLACK;
      endcase
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid2_q <= 1'b0;
      color_q  <= 12'h000;
    end else begin
      valid2_q <= valid1_q;
      color_q  <= color_d;
    end
  end

  assign color       = color_q;
  assign color_valid = valid2_q;

endmodule
